fifo_push_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/fifo_push_arbiter_rr_pick.sv | 34 +++
 rtl/fifo_push_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the fifo push arbiter.
// Optional build macro FIFO_ARB_ERROR_EN is consumed by fifo_push_arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int DEFAULT_BURST_LENGTH = 4;

   // Credits must hold nrOfEntries-1 without overflow.
   function automatic int credit_width(input int entries);
      return $clog2(entries) + 1;
   endfunction

   function automatic int beat_width(input int burst);
      return $clog2(burst) + 1;
   endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after last,
// wrapping N-1 -> 0, with the last position itself considered final.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  request,
   input  logic [IW-1:0] last,
   input  logic [N-1:0]  exclude,
   output logic [N-1:0]  pick,
   output logic          valid
);

   logic [N-1:0] eligible;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_elig
         assign eligible[gi] = request[gi] & ~exclude[gi];
      end
   endgenerate

   always_comb begin
      pick  = '0;
      valid = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!valid && eligible[(int'(last) + k) % N]) begin
            pick[(int'(last) + k) % N] = 1'b1;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one fifo push port, with credit
// tracking of fifo occupancy. Define FIFO_ARB_ERROR_EN for popError + checks.
module fifo_push_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int nrOfRequesters = 4,
   parameter int bitWidth       = 32,
   parameter int nrOfEntries    = 16,
   parameter int burstLength    = DEFAULT_BURST_LENGTH
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [nrOfRequesters-1:0]            request,
   input  logic [nrOfRequesters*bitWidth-1:0]   requestData,
   output logic [nrOfRequesters-1:0]            grant,
   output logic                                 fifoPush,
   output logic [bitWidth-1:0]                  fifoPushData,
   input  logic                                 fifoPop,
   output logic [credit_width(nrOfEntries)-1:0] credits,
   output logic                                 busy
`ifdef FIFO_ARB_ERROR_EN
   ,
   output logic                                 popError
`endif
);

   localparam int CW = credit_width(nrOfEntries);
   localparam int BW = beat_width(burstLength);
   localparam int IW = (nrOfRequesters > 1) ? $clog2(nrOfRequesters) : 1;
   localparam logic [CW-1:0] MAX_CREDITS = CW'(nrOfEntries - 1);
   localparam logic [BW-1:0] LAST_BEAT   = BW'(burstLength - 1);
   localparam logic [IW-1:0] LAST_INDEX  = IW'(nrOfRequesters - 1);

   arb_state_t                state_reg, state_next;
   logic [IW-1:0]             owner_reg, owner_next;
   logic [IW-1:0]             last_owner_reg, last_owner_next;
   logic [BW-1:0]             beat_count_reg, beat_count_next;
   logic [CW-1:0]             credits_reg, credits_next;
   logic [nrOfRequesters-1:0] grant_reg, grant_next;

   logic                      credit_ok;
   logic                      accept;
   logic                      pop_effective;
   logic                      release_burst;
   logic [IW-1:0]             pick_last;
   logic [nrOfRequesters-1:0] pick_exclude;
   logic [nrOfRequesters-1:0] pick_onehot;
   logic                      pick_valid;
   logic [IW-1:0]             pick_index;
   logic [bitWidth-1:0]       data_slice [nrOfRequesters];

   genvar gi;
   generate
      for (gi = 0; gi < nrOfRequesters; gi++) begin : g_slice
         assign data_slice[gi] = requestData[gi*bitWidth +: bitWidth];
      end
   endgenerate

   assign credit_ok     = (credits_reg != '0);
   assign grant         = grant_reg & {nrOfRequesters{credit_ok}};
   assign accept        = |(grant & request);
   assign fifoPush      = accept;
   assign fifoPushData  = data_slice[owner_reg];
   assign credits       = credits_reg;
   assign busy          = (state_reg == BURST);
   // A pop on an empty fifo does nothing in the fifo, so credits saturate.
   assign pop_effective = fifoPop && (credits_reg != MAX_CREDITS);

   assign release_burst = (accept && (beat_count_reg == LAST_BEAT))
                        || !request[owner_reg]
                        || (!credit_ok && !fifoPop);

   // In BURST grant_reg is the owner one-hot; keep the owner only when alone.
   assign pick_last    = (state_reg == BURST) ? owner_reg : last_owner_reg;
   assign pick_exclude = (request == grant_reg) ? '0 : grant_reg;

   rr_pick #(
      .N  (nrOfRequesters),
      .IW (IW)
   ) u_rr_pick (
      .request (request),
      .last    (pick_last),
      .exclude (pick_exclude),
      .pick    (pick_onehot),
      .valid   (pick_valid)
   );

   always_comb begin
      pick_index = '0;
      for (int i = 0; i < nrOfRequesters; i++) begin
         if (pick_onehot[i]) pick_index = pick_index | IW'(i);
      end
   end

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      beat_count_next = beat_count_reg;
      grant_next      = grant_reg;
      credits_next    = credits_reg - CW'(accept) + CW'(pop_effective);
      case (state_reg)
         IDLE: begin
            if (pick_valid && credit_ok) begin
               state_next      = BURST;
               owner_next      = pick_index;
               grant_next      = pick_onehot;
               beat_count_next = '0;
            end
         end
         BURST: begin
            if (accept) beat_count_next = beat_count_reg + 1'b1;
            if (release_burst) begin
               last_owner_next = owner_reg;
               beat_count_next = '0;
               if (pick_valid && (credits_next != '0)) begin
                  owner_next = pick_index;
                  grant_next = pick_onehot;
               end else begin
                  state_next = IDLE;
                  grant_next = '0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= '0;
         last_owner_reg <= LAST_INDEX;
         beat_count_reg <= '0;
         credits_reg    <= MAX_CREDITS;
         grant_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         beat_count_reg <= beat_count_next;
         credits_reg    <= credits_next;
         grant_reg      <= grant_next;
      end
   end

`ifdef FIFO_ARB_ERROR_EN
   logic pop_error_reg;

   always_ff @(posedge clock) begin
      if (reset)                                         pop_error_reg <= 1'b0;
      else if (fifoPop && (credits_reg == MAX_CREDITS))  pop_error_reg <= 1'b1;
   end

   assign popError = pop_error_reg;

   always_ff @(posedge clock) begin
      if (!reset) assert ($onehot0(grant));
   end
`endif

endmodule
